// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage core. Each cycle it decides
// whether the PC, IF/ID, ID/EX and EX/MEM registers load, hold or take a
// bubble. It resolves three hazard sources in fixed priority:
//   1. data-memory wait (freeze the whole pipe),
//   2. taken branch/jump redirect (flush the wrong-path instructions),
//   3. load-use dependency (one-cycle stall with a bubble into EX).
// A small FSM (RUN / MEM_WAIT / HALT) tracks multi-cycle memory waits and
// halts the core with a sticky error when a wait exceeds MAX_WAIT cycles.
//
// Parameters:
//   MAX_WAIT  longest tolerated run of memory-wait cycles, 0 = no timeout
//   CNT_W     width of the performance counters
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   id_rs1, id_rs2                source registers of the instruction in ID
//   id_uses_rs1, id_uses_rs2      ID instruction really reads rs1 / rs2
//   ex_rd, ex_MemRead             destination and load flag held in ID/EX
//   branch_taken                  EX resolved a taken branch or jump
//   dmem_req, dmem_ready          data-memory access handshake from MEM
//   pc_en .. ex_mem_en            pipeline register load enables
//   if_id_flush, id_ex_flush,
//   mem_wb_flush                  bubble insertion controls
//   pc_redirect                   PC selects the branch target
//   mem_timeout                   sticky wait-timeout error
//   state                         FSM state (0 RUN, 1 MEM_WAIT, 2 HALT)
//   perf_stall, perf_loaduse,
//   perf_flush                    saturating performance counters
//
// Build option:
//   HAZARD_PERF_EN  when defined the performance counters are built; when
//                   undefined the three perf ports are tied to zero.
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             pc_redirect,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_loaduse,
    output logic [CNT_W-1:0] perf_flush
);

    // One spare bit above what MAX_WAIT needs, so the counter can saturate
    // rather than wrap even when the timeout is disabled.
    localparam int WAIT_W = $clog2(MAX_WAIT + 1) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam bit TIMEOUT_EN = (MAX_WAIT != 0);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t            cur_state;
    logic [WAIT_W-1:0] wait_cnt;

    logic freeze;
    logic load_use;
    logic do_freeze;
    logic do_redirect;
    logic do_loaduse;

    assign state = cur_state;

    // Hazard detection. A memory access that is not ready freezes the pipe
    // whether it starts this cycle (RUN) or is already outstanding (MEM_WAIT).
    // A load writing x0 never creates a dependency.
    always_comb begin
        freeze   = ((cur_state == RUN) && dmem_req && !dmem_ready) ||
                   ((cur_state == MEM_WAIT) && !dmem_ready);
        load_use = ex_MemRead && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

    // Priority resolution: HALT, freeze, redirect, load-use, normal. The
    // redirect outranks load-use because the dependent instruction in ID is
    // on the wrong path and is being flushed anyway. A branch seen during a
    // freeze needs no latch: EX is held, so it is seen again on release.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        pc_redirect  = 1'b0;
        do_freeze    = 1'b0;
        do_redirect  = 1'b0;
        do_loaduse   = 1'b0;
        if (cur_state == HALT) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (freeze) begin
            do_freeze    = 1'b1;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (branch_taken) begin
            do_redirect = 1'b1;
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            do_loaduse  = 1'b1;
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Memory-wait FSM. wait_cnt counts the not-ready cycles seen so far; the
    // core halts when one more not-ready cycle arrives after MAX_WAIT of them.
    // HALT is terminal until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (cur_state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        cur_state <= MEM_WAIT;
                        wait_cnt  <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        cur_state <= RUN;
                        wait_cnt  <= '0;
                    end else if (TIMEOUT_EN && (wait_cnt == WAIT_LIMIT)) begin
                        cur_state   <= HALT;
                        mem_timeout <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HALT: begin
                    cur_state <= HALT;
                end
                default: begin
                    cur_state <= RUN;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters. They naturally hold in HALT because no
    // hazard action is taken there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall   <= '0;
            perf_loaduse <= '0;
            perf_flush   <= '0;
        end else begin
            if (do_freeze && (perf_stall != '1))
                perf_stall <= perf_stall + CNT_W'(1);
            if (do_loaduse && (perf_loaduse != '1))
                perf_loaduse <= perf_loaduse + CNT_W'(1);
            if (do_redirect && (perf_flush != '1))
                perf_flush <= perf_flush + CNT_W'(1);
        end
    end
`else
    assign perf_stall   = '0;
    assign perf_loaduse = '0;
    assign perf_flush   = '0;
`endif

endmodule
